// File: rtl/filter_pkg.sv
// Types and constants shared by the window sequencer and the systolic filter,
// so both agree on the w1..w9 tap order.
package filter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  localparam int TAP_COUNT  = 9;
  localparam int DATA_W_DEF = 8;

  // Row-major window index of each filter weight: w1 top-left .. w9 bottom-right.
  localparam int TAP_W1 = 0;
  localparam int TAP_W2 = 1;
  localparam int TAP_W3 = 2;
  localparam int TAP_W4 = 3;
  localparam int TAP_W5 = 4;
  localparam int TAP_W6 = 5;
  localparam int TAP_W7 = 6;
  localparam int TAP_W8 = 7;
  localparam int TAP_W9 = 8;

  function automatic int tap_index(input int row, input int col);
    return row * 3 + col;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of pixels: synchronous write, asynchronous read at the same address.
module line_buffer #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/window_sequencer.sv
// Buffers the raster pixel stream and replays each interior 3x3 window
// serially, row-major, one tap per clock for the systolic filter.
module window_sequencer
  import filter_pkg::*;
#(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sof,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [DATA_W-1:0] win_data,
  output logic              win_valid,
  output logic              frame_done,
  output logic              overrun
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);

  state_e            state_q, state_d;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [3:0]        tap_q;
  logic              sof_pend_q;
  logic              win_valid_q, frame_done_q, overrun_q;
  logic [DATA_W-1:0] win_data_q;
  logic [DATA_W-1:0] win_q [TAP_COUNT];
  logic [DATA_W-1:0] lb0_rd, lb1_rd;
  logic              accept, burst_end, col_last, row_last, interior;

  assign accept    = (state_q == IDLE) && rx_valid && !sof;
  assign burst_end = (state_q == EMIT) && (tap_q == 4'(TAP_COUNT));
  assign col_last  = (col_q == COL_W'(IMG_WIDTH - 1));
  assign row_last  = (row_q == ROW_W'(IMG_HEIGHT - 1));
  assign interior  = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

  // lb0 holds the previous row, lb1 the row before; lb1 takes lb0's old value.
  line_buffer #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W)) u_lb0 (
    .clk(clk), .we(accept), .addr(col_q), .wdata(rx_data), .rdata(lb0_rd)
  );
  line_buffer #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W)) u_lb1 (
    .clk(clk), .we(accept), .addr(col_q), .wdata(lb0_rd), .rdata(lb1_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && interior) state_d = EMIT;
      EMIT:    if (burst_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_ready = (state_q == IDLE);
  end

  assign win_data   = win_data_q;
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

  // Window contents need no reset: a window is only emitted after three fresh columns.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_q[tap_index(r, 0)] <= win_q[tap_index(r, 1)];
        win_q[tap_index(r, 1)] <= win_q[tap_index(r, 2)];
      end
      win_q[TAP_W3] <= lb1_rd;
      win_q[TAP_W6] <= lb0_rd;
      win_q[TAP_W9] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      tap_q        <= '0;
      sof_pend_q   <= 1'b0;
      win_valid_q  <= 1'b0;
      win_data_q   <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (rx_valid && (state_q == EMIT)) overrun_q <= 1'b1;
      if (state_q == IDLE) begin
        if (sof) begin
          row_q      <= '0;
          col_q      <= '0;
          sof_pend_q <= 1'b0;
        end else if (rx_valid) begin
          if (col_last) begin
            col_q <= '0;
            if (row_last) begin
              row_q        <= '0;
              frame_done_q <= 1'b1;
            end else begin
              row_q <= row_q + ROW_W'(1);
            end
          end else begin
            col_q <= col_q + COL_W'(1);
          end
        end
      end else begin
        if (sof) sof_pend_q <= 1'b1;
        if (tap_q < 4'(TAP_COUNT)) begin
          win_data_q  <= win_q[tap_q];
          win_valid_q <= 1'b1;
          tap_q       <= tap_q + 4'd1;
        end else begin
          // A start-of-frame seen during the burst takes effect once it finishes.
          win_valid_q <= 1'b0;
          tap_q       <= '0;
          if (sof_pend_q || sof) begin
            row_q      <= '0;
            col_q      <= '0;
            sof_pend_q <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_window_sequencer.sv
// Directed bench for window_sequencer on a 4x4 image, one pixel every 20 cycles.
module tb_window_sequencer;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, sof, rx_valid;
  logic [DW-1:0] rx_data;
  logic          rx_ready, win_valid, frame_done, overrun;
  logic [DW-1:0] win_data;

  window_sequencer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .sof(sof), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .win_data(win_data), .win_valid(win_valid),
    .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Offsets of the nine row-major taps from the top-left pixel (row stride 4).
  int       tap_off [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
  int       kern    [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
  logic [DW-1:0] taps [9];
  int       ntap, nbusy, nfd, nruns;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mode 0 plain, 1 overrun injection, 2 sof mid-burst, 3 rst mid-burst
  task automatic send_pix(input int p, input int mode);
    logic prev_v;
    rx_data  = 8'(p);
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    ntap = 0; nbusy = 0; nfd = 0; nruns = 0; prev_v = 1'b0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      if (win_valid) begin
        if (ntap < 9) taps[ntap] = win_data;
        ntap++;
        if (!prev_v) nruns++;
      end
      prev_v = win_valid;
      if (!rx_ready) nbusy++;
      if (frame_done) nfd++;
      if (mode == 1 && i == 3) begin rx_data = 8'hEE; rx_valid = 1'b1; end
      if (mode == 1 && i == 4) rx_valid = 1'b0;
      if (mode == 2 && i == 3) sof = 1'b1;
      if (mode == 2 && i == 4) sof = 1'b0;
      if (mode == 3 && i == 4) rst = 1'b1;
      if (mode == 3 && i == 5) begin
        check("rst_win_valid", 32'(win_valid), 0);
        check("rst_rx_ready", 32'(rx_ready), 1);
        check("rst_win_data", 32'(win_data), 0);
        rst = 1'b0;
      end
    end
    $display("[TB] pixel %0d mode %0d: taps=%0d busy=%0d frame_done=%0d", p, mode, ntap, nbusy, nfd);
  endtask

  task automatic check_pix(input int idx, input int p);
    int r, c, acc;
    r = idx / W;
    c = idx % W;
    if (r >= 2 && c >= 2) begin
      check($sformatf("p%0d_ntap", p), ntap, 9);
      check($sformatf("p%0d_runs", p), nruns, 1);
      check($sformatf("p%0d_busy", p), nbusy, 10);
      acc = 0;
      for (int j = 0; j < 9; j++) begin
        check($sformatf("p%0d_tap%0d", p, j), 32'(taps[j]), p - 10 + tap_off[j]);
        acc += kern[j] * int'(taps[j]);
      end
      if (p == 11) check("filter_out_p11", acc >> 4, 6);
    end else begin
      check($sformatf("p%0d_ntap", p), ntap, 0);
      check($sformatf("p%0d_busy", p), nbusy, 0);
    end
    check($sformatf("p%0d_frame_done", p), nfd, (idx == W * H - 1) ? 1 : 0);
  endtask

  task automatic send_frame();
    for (int idx = 0; idx < W * H; idx++) begin
      send_pix(idx + 1, 0);
      check_pix(idx, idx + 1);
    end
  endtask

  task automatic send_prefix(input int n);
    for (int idx = 0; idx < n; idx++) begin
      send_pix(idx + 1, 0);
      check_pix(idx, idx + 1);
    end
  endtask

  initial begin
    rst = 1'b1; sof = 1'b0; rx_valid = 1'b0; rx_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_rx_ready", 32'(rx_ready), 1);
    check("reset_win_valid", 32'(win_valid), 0);
    check("reset_win_data", 32'(win_data), 0);
    check("reset_frame_done", 32'(frame_done), 0);
    check("reset_overrun", 32'(overrun), 0);

    // Two back-to-back frames must give identical bursts.
    send_frame();
    check("no_overrun", 32'(overrun), 0);
    send_frame();

    // Overrun during the burst after pixel 11.
    send_prefix(10);
    send_pix(11, 1);
    check_pix(10, 11);
    check("overrun_set", 32'(overrun), 1);
    for (int idx = 11; idx < W * H; idx++) begin
      send_pix(idx + 1, 0);
      check_pix(idx, idx + 1);
    end
    send_frame();
    check("overrun_sticky", 32'(overrun), 1);

    // sof in IDLE after pixel 6, with rx_valid also high.
    send_prefix(6);
    @(negedge clk);
    sof = 1'b1; rx_valid = 1'b1; rx_data = 8'hAA;
    @(posedge clk);
    #1 sof = 1'b0; rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("sof_idle_rx_ready", 32'(rx_ready), 1);
    check("sof_idle_win_valid", 32'(win_valid), 0);
    send_frame();

    // sof during a burst is deferred until the burst completes.
    send_prefix(10);
    send_pix(11, 2);
    check_pix(10, 11);
    send_frame();

    // rst in the middle of a burst.
    send_prefix(10);
    send_pix(11, 3);
    check("post_rst_rx_ready", 32'(rx_ready), 1);
    check("post_rst_overrun", 32'(overrun), 0);
    send_frame();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
